// File: rtl/dp_seq_pkg.sv
// Shared types and helpers for the audio datapath read sequencer.
// Channel indices need one extra code point so that "no channel" can be NUM_FX.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MAIN_RD = 3'd1,
    FX_RD   = 3'd2,
    READY   = 3'd3,
    XFER    = 3'd4
  } state_t;

  localparam int MAX_FX = 8;
  localparam int CH_W   = $clog2(MAX_FX + 1);
  localparam int WAIT_W = 4;

  // Lowest enabled channel strictly above 'from'; num_fx when none is left.
  // Pass from = -1 to find the first enabled channel.
  function automatic logic [CH_W-1:0] next_en_above(
    input logic [MAX_FX-1:0] mask,
    input int                from,
    input int                num_fx
  );
    logic [CH_W-1:0] r;
    r = CH_W'(num_fx);
    for (int j = MAX_FX - 1; j >= 0; j--) begin
      if (j > from && j < num_fx && mask[j]) begin
        r = CH_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dp_seq_fsm_wait_cnt.sv
// Loadable down-counter used to time each read strobe; done while the count is zero.
module dp_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dp_seq_fsm.sv
// Per-frame read sequencer: main buffer, then each enabled effect buffer, then
// a ready/transmit handshake toward the transfer stage. All outputs registered.
//
//   state   | meaning
//   IDLE    | waiting for start
//   MAIN_RD | main_read strobe held for RD_WAIT cycles
//   FX_RD   | fx_read[idx] strobe held for RD_WAIT cycles
//   READY   | tfr_ready high, waiting for transmit
//   XFER    | transfer running, waiting for transmit to drop
module dp_seq_fsm
  import dp_seq_pkg::*;
#(
  parameter int NUM_FX  = 2,
  parameter int RD_WAIT = 1,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               transmit,
  input  logic [NUM_FX-1:0]  fx_en,
  input  logic               clr_ovr,
  output logic               main_read,
  output logic [NUM_FX-1:0]  fx_read,
  output logic               tfr_ready,
  output logic               busy,
  output logic               overrun,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [CH_W-1:0]   NO_CH    = CH_W'(NUM_FX);
  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(RD_WAIT - 1);

  state_t            state, state_d;
  logic [CH_W-1:0]   idx, idx_d, nxt;
  logic [NUM_FX-1:0] mask, mask_d;
  logic [MAX_FX-1:0] mask_ext;
  logic              cnt_load, cnt_dec, cnt_done;
  logic              frame_inc, ovr_set;

  logic              main_read_d, tfr_ready_d, busy_d;
  logic [NUM_FX-1:0] fx_read_d;

  assign mask_ext = MAX_FX'(mask);
  assign ovr_set  = start && (state != IDLE);

  dp_wait_cnt #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_LD),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      mask      <= '0;
      main_read <= 1'b0;
      fx_read   <= '0;
      tfr_ready <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      mask      <= mask_d;
      main_read <= main_read_d;
      fx_read   <= fx_read_d;
      tfr_ready <= tfr_ready_d;
      busy      <= busy_d;
      // a new overrun beats a simultaneous clear
      overrun   <= ovr_set | (overrun & ~clr_ovr);
      if (frame_inc) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    mask_d    = mask;
    nxt       = NO_CH;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    frame_inc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mask_d   = fx_en;
          idx_d    = '0;
          cnt_load = 1'b1;
          state_d  = MAIN_RD;
        end
      end
      MAIN_RD: begin
        if (cnt_done) begin
          nxt = next_en_above(mask_ext, -1, NUM_FX);
          if (nxt == NO_CH) begin
            state_d = READY;
          end else begin
            state_d  = FX_RD;
            idx_d    = nxt;
            cnt_load = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FX_RD: begin
        if (cnt_done) begin
          nxt = next_en_above(mask_ext, int'(idx), NUM_FX);
          if (nxt == NO_CH) begin
            state_d = READY;
          end else begin
            idx_d    = nxt;
            cnt_load = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      READY: begin
        if (transmit) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (!transmit) begin
          state_d   = IDLE;
          idx_d     = '0;
          frame_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    main_read_d = (state_d == MAIN_RD);
    tfr_ready_d = (state_d == READY);
    busy_d      = (state_d != IDLE);
    fx_read_d   = '0;
    for (int i = 0; i < NUM_FX; i++) begin
      fx_read_d[i] = (state_d == FX_RD) && (idx_d == CH_W'(i));
    end
  end

endmodule

// File: tb/tb_dp_seq_fsm.sv
// Scoreboard bench for dp_seq_fsm: stimulus queues expected strobe/frame events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_dp_seq_fsm;

  localparam int NUM_FX  = 2;
  localparam int RD_WAIT = 3;
  localparam int FRAME_W = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               transmit = 1'b0;
  logic [NUM_FX-1:0]  fx_en = '0;
  logic               clr_ovr = 1'b0;
  logic               main_read;
  logic [NUM_FX-1:0]  fx_read;
  logic               tfr_ready;
  logic               busy;
  logic               overrun;
  logic [FRAME_W-1:0] frame_cnt;

  dp_seq_fsm #(.NUM_FX(NUM_FX), .RD_WAIT(RD_WAIT), .FRAME_W(FRAME_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .transmit  (transmit),
    .fx_en     (fx_en),
    .clr_ovr   (clr_ovr),
    .main_read (main_read),
    .fx_read   (fx_read),
    .tfr_ready (tfr_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [NUM_FX:0]    exp_strobe[$];
  int                 exp_fc[$];
  int                 fc_model = 0;
  bit                 ovr_model = 0;
  logic [FRAME_W-1:0] prev_fc = '0;
  logic [NUM_FX:0]    strobe;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every active strobe cycle and every frame count change is an event
  always @(negedge clk) begin
    if (reset) begin
      prev_fc = frame_cnt;
    end else begin
      strobe = {main_read, fx_read};
      if (strobe != '0) begin
        if (exp_strobe.size() == 0) check("unexpected_strobe", strobe, 0);
        else check("strobe_seq", strobe, exp_strobe.pop_front());
      end
      if (frame_cnt != prev_fc) begin
        if (exp_fc.size() == 0) check("unexpected_frame_cnt", frame_cnt, prev_fc);
        else check("frame_cnt", frame_cnt, exp_fc.pop_front());
        prev_fc = frame_cnt;
      end
    end
  end

  // Queue the read schedule, fire start, and wait (bounded) for tfr_ready.
  task automatic begin_frame(input logic [NUM_FX-1:0] m, input bit pre_tx,
                             input bit ovr_pulse, input bit ovr_clr);
    int n_en = 0;
    int rd;
    int t;
    logic [NUM_FX:0] e;
    for (int r = 0; r < RD_WAIT; r++) exp_strobe.push_back({1'b1, {NUM_FX{1'b0}}});
    for (int ch = 0; ch < NUM_FX; ch++) begin
      if (m[ch]) begin
        n_en++;
        e = '0;
        e[ch] = 1'b1;
        for (int r = 0; r < RD_WAIT; r++) exp_strobe.push_back(e);
      end
    end
    rd = (1 + n_en) * RD_WAIT;
    @(negedge clk);
    start = 1'b1;
    fx_en = m;
    if (pre_tx) transmit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fx_en = NUM_FX'($urandom);
    check("main_latency", main_read, 1);
    check("busy_on_start", busy, 1);
    t = 1;
    while (tfr_ready !== 1'b1 && t < rd + 8) begin
      if (ovr_pulse && t == RD_WAIT + 1) begin
        start = 1'b1;
        clr_ovr = ovr_clr;
      end
      @(negedge clk);
      t++;
      if (start) begin
        start = 1'b0;
        clr_ovr = 1'b0;
        ovr_model = 1'b1;
        check("overrun_set", overrun, 1);
      end
    end
    check("ready_time", t, rd + 1);
  endtask

  task automatic run_frame(input logic [NUM_FX-1:0] m, input bit pre_tx, input int ready_wait,
                           input int xfer_len, input bit ovr_pulse, input bit ovr_clr);
    begin_frame(m, pre_tx, ovr_pulse, ovr_clr);
    if (pre_tx) begin
      @(negedge clk);
      check("ready_single", tfr_ready, 0);
    end else begin
      repeat (ready_wait) @(negedge clk);
      check("ready_hold", tfr_ready, 1);
      transmit = 1'b1;
      @(negedge clk);
      check("ready_drop", tfr_ready, 0);
    end
    check("xfer_busy", busy, 1);
    repeat (xfer_len) @(negedge clk);
    transmit = 1'b0;
    fc_model = (fc_model + 1) % (1 << FRAME_W);
    exp_fc.push_back(fc_model);
    @(negedge clk);
    check("frame_done", busy, 0);
    check("overrun_flag", overrun, ovr_model);
    check("strobes_drained", exp_strobe.size(), 0);
    @(negedge clk);
    check("fc_drained", exp_fc.size(), 0);
  endtask

  task automatic clear_ovr();
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    ovr_model = 1'b0;
    check("overrun_clr", overrun, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #19;
    check("rst_main_read", main_read, 0);
    check("rst_fx_read", fx_read, 0);
    check("rst_tfr_ready", tfr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    #3 reset = 1'b0;

    repeat (4) begin
      @(negedge clk);
      transmit = ~transmit;
    end
    @(negedge clk);
    transmit = 1'b0;
    check("idle_tx_busy", busy, 0);
    check("idle_tx_ready", tfr_ready, 0);
    check("idle_tx_frame_cnt", frame_cnt, 0);

    run_frame(2'b11, 0, 2, 5, 0, 0);
    run_frame(2'b11, 0, 0, 5, 0, 0);
    run_frame(2'b10, 0, 1, 1, 0, 0);
    run_frame(2'b00, 0, 1, 0, 0, 0);
    run_frame(2'b01, 1, 0, 2, 0, 0);

    run_frame(2'b11, 0, 1, 2, 1, 0);
    repeat (3) @(negedge clk);
    check("no_second_frame", busy, 0);
    check("overrun_sticky", overrun, 1);
    clear_ovr();
    run_frame(2'b01, 0, 0, 1, 1, 1);
    clear_ovr();

    begin_frame(2'b11, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", tfr_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_overrun", overrun, 0);
    fc_model = 0;
    ovr_model = 0;
    exp_fc.delete();
    exp_strobe.delete();
    #22 reset = 1'b0;
    repeat (4) run_frame(2'b11, 0, 0, 1, 0, 0);
    check("wrap_frame_cnt", frame_cnt, 0);

    for (int n = 0; n < 30; n++) begin
      logic [NUM_FX-1:0] m;
      m = NUM_FX'($urandom_range(0, (1 << NUM_FX) - 1));
      run_frame(m, ($urandom % 4) == 0, $urandom_range(0, 3), $urandom_range(0, 4),
                (m != '0) && (($urandom % 5) == 0), ($urandom % 3) == 0);
      if (ovr_model && ($urandom % 2) == 0) clear_ovr();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
